// File: rtl/dmux16_router.sv
// dmux16_router: registered 1-to-2 word demux with per-channel holding slots and accept counters
module dmux16_router #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic                 sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a_out,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [WIDTH-1:0]     b_out,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [CNT_WIDTH-1:0] a_count,
  output logic [CNT_WIDTH-1:0] b_count
);
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 av_q, av_d, bv_q, bv_d;
  logic [CNT_WIDTH-1:0] ac_q, ac_d, bc_q, bc_d;
  logic                 acc_a, acc_b;
  // a slot is free when empty or draining this cycle; the accept loads only the selected slot
  always_comb begin
    in_ready = sel ? (!bv_q || b_ready) : (!av_q || a_ready);
    acc_a    = in_valid && in_ready && !sel;
    acc_b    = in_valid && in_ready && sel;
    a_d      = acc_a ? in : a_q;
    b_d      = acc_b ? in : b_q;
    av_d     = acc_a || (av_q && !a_ready);
    bv_d     = acc_b || (bv_q && !b_ready);
    ac_d     = ac_q + CNT_WIDTH'(acc_a);
    bc_d     = bc_q + CNT_WIDTH'(acc_b);
  end
  // slot, valid and counter registers; reset discards any held words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      av_q <= 1'b0;
      bv_q <= 1'b0;
      ac_q <= '0;
      bc_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      av_q <= av_d;
      bv_q <= bv_d;
      ac_q <= ac_d;
      bc_q <= bc_d;
    end
  end
  assign a_out   = a_q;
  assign b_out   = b_q;
  assign a_valid = av_q;
  assign b_valid = bv_q;
  assign a_count = ac_q;
  assign b_count = bc_q;
endmodule

// File: tb/tb_dmux16_router.sv
// tb_dmux16_router: queue-scoreboard bench with directed scenarios and random traffic
module tb_dmux16_router;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in = '0;
  logic        sel = 1'b0, in_valid = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
  logic        in_ready, a_valid, b_valid;
  logic [15:0] a_out, b_out;
  logic [7:0]  a_count, b_count;
  int          n_vec = 0, n_err = 0, n_aaaa = 0, ca = 0, cb = 0;
  logic [15:0] qa[$], qb[$];

  dmux16_router #(.WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in(in), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_out(a_out), .a_valid(a_valid), .a_ready(a_ready),
    .b_out(b_out), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready();
    return sel ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
  endfunction

  task automatic tick();
    logic da, db, acc;
    #1;
    chk("in_ready", in_ready, model_ready());
    chk("a_valid", a_valid, qa.size() != 0);
    chk("b_valid", b_valid, qb.size() != 0);
    if (qa.size() != 0) chk("a_out", a_out, qa[0]);
    if (qb.size() != 0) chk("b_out", b_out, qb[0]);
    chk("a_count", a_count, ca % 256);
    chk("b_count", b_count, cb % 256);
    da  = qa.size() != 0 && a_ready;
    db  = qb.size() != 0 && b_ready;
    acc = in_valid && model_ready();
    @(posedge clk);
    if (da) begin
      if (qa[0] == 16'hAAAA) n_aaaa++;
      void'(qa.pop_front());
    end
    if (db) void'(qb.pop_front());
    if (acc && sel) begin
      qb.push_back(in);
      cb++;
    end
    if (acc && !sel) begin
      qa.push_back(in);
      ca++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d, input logic ar, input logic br);
    in_valid = v;
    sel      = s;
    in       = d;
    a_ready  = ar;
    b_ready  = br;
    tick();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
    qa.delete();
    qb.delete();
    ca = 0;
    cb = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    async_reset();
    // basic route
    drive(1, 0, 16'hBEEF, 1, 0);
    chk("t2_a_out", a_out, 16'hBEEF);
    chk("t2_a_cnt", a_count, 1);
    chk("t2_b_valid", b_valid, 0);
    drive(0, 0, 0, 1, 1);
    // streaming on B
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 16'(i), 1, 1);
      chk("t3_b_out", b_out, i);
    end
    drive(0, 0, 0, 1, 1);
    chk("t3_b_cnt", b_count, 8);
    // independent stall
    drive(1, 0, 16'h1234, 0, 1);
    in_valid = 1; sel = 0; in = 16'h9999; a_ready = 0;
    #1 chk("t4_stall_rdy", in_ready, 0);
    tick();
    chk("t4_a_hold", a_out, 16'h1234);
    drive(1, 1, 16'h5678, 0, 1);
    chk("t4_b_out", b_out, 16'h5678);
    drive(1, 0, 16'h9999, 1, 1);
    chk("t4_a_new", a_out, 16'h9999);
    drive(0, 0, 0, 1, 1);
    // drain and load same cycle
    drive(1, 0, 16'hAAAA, 0, 1);
    drive(1, 0, 16'h5555, 1, 1);
    chk("t5_a_out", a_out, 16'h5555);
    chk("t5_a_valid", a_valid, 1);
    drive(0, 0, 0, 1, 1);
    chk("t5_once", n_aaaa, 1);
    // reset mid-stream, then accept from empty
    drive(1, 0, 16'h7777, 0, 0);
    async_reset();
    drive(1, 0, 16'h4242, 0, 0);
    chk("t1_a_cnt", a_count, 1);
    chk("t1_a_out", a_out, 16'h4242);
    drive(0, 0, 0, 1, 1);
    // counter wrap on B
    for (int i = 0; i < 256; i++) drive(1, 1, 16'(i * 3), 1, 1);
    chk("t6_wrap", b_count, 0);
    drive(1, 1, 16'hCAFE, 1, 1);
    chk("t6_after", b_count, 1);
    chk("t6_a_cnt", a_count, 1);
    // random traffic
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 9) < 8, 1'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
    drive(0, 0, 0, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmux16_router.md
Name: dmux16_router

Overview:
- Registered 1-to-2 demultiplexer for 16-bit word streams. It is the splitting counterpart of the 16-bit two-input word multiplexer.
- One input word is steered by `sel` to channel A (`sel=0`) or channel B (`sel=1`).
- Each output channel has its own one-entry holding register and valid/ready handshake, so a stalled destination never blocks the other.
- Per-channel word counters support debug and bench checking.

Parameters:
- WIDTH, 16, data word width in bits.
- CNT_WIDTH, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  input data word.
- sel  input  1  destination select: 0 = channel A, 1 = channel B; sampled with `in`.
- in_valid  input  1  upstream holds a valid word on `in`/`sel`.
- in_ready  output  1  router accepts the word this cycle (combinational).
- a_out  output  WIDTH  channel A held word.
- a_valid  output  1  channel A holds a word.
- a_ready  input  1  channel A consumer takes the word this cycle.
- b_out  output  WIDTH  channel B held word.
- b_valid  output  1  channel B holds a word.
- b_ready  input  1  channel B consumer takes the word this cycle.
- a_count  output  CNT_WIDTH  words accepted for channel A, modulo 2^CNT_WIDTH.
- b_count  output  CNT_WIDTH  words accepted for channel B, modulo 2^CNT_WIDTH.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While `reset`=1, outputs are forced immediately, without waiting for clk:
  - `a_out` = `b_out` = 0
  - `a_valid` = `b_valid` = 0
  - `a_count` = `b_count` = 0
- Reset mid-operation: held words are discarded, not delivered. The first edge after `reset` deasserts behaves as from the empty state.
- Each channel slot is either EMPTY (`x_valid`=0) or FULL (`x_valid`=1).
- Drain: `x_drain` = `x_valid` & `x_ready`.
- Slot free: channel X is free when `x_valid`=0 or `x_drain`=1 (pass-through on drain).
- `in_ready` = `sel` ? B free : A free. It is a combinational function of `sel`, the valids and the readys; it never depends on `in_valid`.
- Accept: `in_valid` & `in_ready`. At the edge, the selected channel loads `x_out` <= `in` and sets `x_valid` <= 1.
- Latency: a word accepted at edge N is visible on `x_out`/`x_valid` after edge N.
- Throughput: 1 word per cycle when the destination is continuously ready.
- Simultaneous drain and load on the same channel: the new word replaces the old one and `x_valid` stays 1. No bubble and no loss.
- Drain without load: `x_valid` <= 0. `x_out` keeps its last value (don't-care for consumers).
- Stall: while `x_valid`=1 and `x_ready`=0, `x_out` is held bit-stable.
- Unselected channel: its data register is never written by an accept; it drains independently.
- `sel` toggling while `in_valid`=0 has no effect.
- Counters: `x_count` increments by 1 on each accepted word routed to X.
  - Wrap-around: 2^CNT_WIDTH−1 → 0, no saturation.
  - Counters count accepts, not drains.
- No word is ever duplicated, dropped or routed to the wrong channel outside reset.

Test Plan:
1. Reset mid-stream: assert `reset` asynchronously between edges while `a_valid`=1 → `a_valid`, `b_valid` and both counts drop to 0 immediately. The first accept after release behaves as from empty.
2. Basic route: `in`=16'hBEEF, `sel`=0, `in_valid`=1, `a_ready`=1 → `a_out`=16'hBEEF, `a_valid`=1 after one edge, `a_count`=1. `b_valid` stays 0 and `b_count`=0.
3. Streaming: 8 words 16'h0001..16'h0008 on `sel`=1 with `b_ready`=1 → `b_out` shows each word one cycle after its accept, with no bubbles. `in_ready` stays 1 and `b_count`=8.
4. Independent stall: fill A (16'h1234) with `a_ready`=0, then offer `sel`=0 → `in_ready`=0 and `a_out` holds 16'h1234. Offer `sel`=1 with 16'h5678 → accepted, `b_out`=16'h5678. Raise `a_ready` → the pending `sel`=0 word is accepted the same cycle A drains.
5. Drain+load same cycle: `a_valid`=1 with 16'hAAAA, `a_ready`=1, `in`=16'h5555, `sel`=0 → after the edge `a_out`=16'h5555 and `a_valid`=1. The scoreboard sees 16'hAAAA consumed exactly once.
6. Counter wrap: 256 accepts to channel B (CNT_WIDTH=8) → `b_count` reads 0. The 257th accept gives `b_count`=1, and `a_count` is unchanged.
